// File: rtl/led_chain_driver.sv
// Serializer for daisy-chained LED driver boards: fetches channel words from a
// framebuffer and shifts them out on parallel chains sharing one serial clock and latch.
module led_chain_driver #(
  parameter int unsigned c_ledboards    = 2,
  parameter int unsigned c_chains       = 1,
  parameter int unsigned c_bps          = 12,
  parameter int unsigned c_clk_div      = 2,
  parameter int unsigned c_lat_len      = 2,
  parameter int unsigned c_mode         = 0,
  parameter int unsigned c_frame_period = 16667
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_start,
  output logic [$clog2(c_ledboards*32)-1:0]   o_addr,
  input  logic [c_chains*c_bps-1:0]           i_data,
  output logic                                o_clk,
  output logic [c_chains-1:0]                 o_dai,
  output logic                                o_lat,
  output logic                                o_busy,
  output logic                                o_frame_done,
  output logic                                o_overrun
);

  localparam int unsigned c_channels = c_ledboards * 32;
  localparam int unsigned c_aw       = $clog2(c_channels);
  localparam int unsigned c_dw       = $clog2(c_clk_div);
  localparam int unsigned c_bw       = (c_bps > 1) ? $clog2(c_bps) : 1;
  localparam int unsigned c_lw       = (c_lat_len > 1) ? $clog2(c_lat_len) : 1;
  localparam int unsigned c_pw       = (c_frame_period > 1) ? $clog2(c_frame_period) : 1;
  localparam int unsigned c_pen      = (c_bps > 1) ? c_bps - 2 : 0;

  localparam logic [c_aw-1:0] c_addr_top = c_aw'(c_channels - 1);
  localparam logic [c_dw-1:0] c_div_half = c_dw'(c_clk_div / 2 - 1);
  localparam logic [c_dw-1:0] c_div_last = c_dw'(c_clk_div - 1);
  localparam logic [c_bw-1:0] c_bit_last = c_bw'(c_bps - 1);
  localparam logic [c_bw-1:0] c_bit_pen  = c_bw'(c_pen);
  localparam logic [c_lw-1:0] c_lat_last = c_lw'(c_lat_len - 1);
  localparam logic [c_pw-1:0] c_per_last = c_pw'(c_frame_period - 1);

  typedef enum logic [1:0] {
    s_idle,
    s_fetch,
    s_shift,
    s_latch
  } state_t;

  state_t            state;
  logic              fetch_data;
  logic              last_word;
  logic [c_dw-1:0]   div_cnt;
  logic [c_bw-1:0]   bit_cnt;
  logic [c_lw-1:0]   lat_cnt;
  logic [c_pw-1:0]   per_cnt;
  logic [c_bps-1:0]  sreg [c_chains];
  logic [c_bps-1:0]  word_c [c_chains];
  logic              tick_c;
  logic              start_req_c;

  // Per-chain view of the framebuffer read data
  for (genvar g = 0; g < int'(c_chains); g++) begin : g_word
    assign word_c[g] = i_data[g*c_bps +: c_bps];
  end

  assign tick_c      = (per_cnt == c_per_last);
  assign start_req_c = (c_mode == 0) ? tick_c : i_start;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= s_idle;
      fetch_data   <= 1'b0;
      last_word    <= 1'b0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      lat_cnt      <= '0;
      per_cnt      <= '0;
      o_addr       <= '0;
      o_clk        <= 1'b0;
      o_dai        <= '0;
      o_lat        <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
      for (int unsigned k = 0; k < c_chains; k++) sreg[k] <= '0;
    end else begin
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
      if (tick_c) per_cnt <= '0;
      else        per_cnt <= per_cnt + 1'b1;

      if (start_req_c && state != s_idle) o_overrun <= 1'b1;

      case (state)
        s_idle: begin
          if (start_req_c) begin
            state      <= s_fetch;
            o_addr     <= c_addr_top;
            o_busy     <= 1'b1;
            fetch_data <= 1'b0;
            last_word  <= 1'b0;
          end
        end

        // Address cycle, then data cycle; the first word loads on the second edge
        s_fetch: begin
          fetch_data <= 1'b1;
          if (fetch_data) begin
            state   <= s_shift;
            div_cnt <= '0;
            bit_cnt <= '0;
            for (int unsigned k = 0; k < c_chains; k++) begin
              o_dai[k] <= word_c[k][c_bps-1];
              sreg[k]  <= word_c[k] << 1;
            end
            if (c_bps == 1) begin
              if (o_addr == '0) last_word <= 1'b1;
              else              o_addr    <= o_addr - 1'b1;
            end
          end
        end

        s_shift: begin
          if (div_cnt == c_div_half) o_clk <= 1'b1;
          if (div_cnt != c_div_last) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            o_clk   <= 1'b0;
            if (bit_cnt == c_bit_last) begin
              bit_cnt <= '0;
              if (last_word) begin
                state   <= s_latch;
                o_lat   <= 1'b1;
                o_dai   <= '0;
                lat_cnt <= '0;
              end else begin
                for (int unsigned k = 0; k < c_chains; k++) begin
                  o_dai[k] <= word_c[k][c_bps-1];
                  sreg[k]  <= word_c[k] << 1;
                end
                if (c_bps == 1) begin
                  if (o_addr == '0) last_word <= 1'b1;
                  else              o_addr    <= o_addr - 1'b1;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              for (int unsigned k = 0; k < c_chains; k++) begin
                o_dai[k] <= sreg[k][c_bps-1];
                sreg[k]  <= sreg[k] << 1;
              end
              // Final bit of the word starts: prefetch the next address
              if (c_bps > 1 && bit_cnt == c_bit_pen) begin
                if (o_addr == '0) last_word <= 1'b1;
                else              o_addr    <= o_addr - 1'b1;
              end
            end
          end
        end

        s_latch: begin
          if (lat_cnt == c_lat_last) begin
            state        <= s_idle;
            o_lat        <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b1;
            o_addr       <= '0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        default: state <= s_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_led_chain_driver.sv
// Bench for led_chain_driver: a triggered instance checked bit-by-bit against a
// scoreboard, plus two periodic instances checked for tick timing and overruns.
module tb_led_chain_driver;

  logic       clk;
  logic       rst_a, rst_bc;
  logic       start_a, start_bc;
  logic [4:0] addr [3];
  logic [7:0] fb   [3];
  logic [1:0] dai  [3];
  logic [2:0] sclk, lat, busy, done, ovr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] sb [$];
  bit bc_done = 0;

  int   rises   [3] = '{0, 0, 0};
  int   lat_cyc [3] = '{0, 0, 0};
  int   done_cnt[3] = '{0, 0, 0};
  int   ovr_cnt [3] = '{0, 0, 0};
  int   busy_up [3] = '{0, 0, 0};
  int   hold    [3] = '{0, 0, 0};
  logic [4:0] paddr [3];
  logic [1:0] pdai  [3];
  logic [2:0] pclk = '0, pbusy = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  led_chain_driver #(.c_ledboards(1), .c_chains(2), .c_bps(4), .c_clk_div(4),
                     .c_lat_len(2), .c_mode(1), .c_frame_period(600)) u_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_start(start_a), .o_addr(addr[0]), .i_data(fb[0]),
    .o_clk(sclk[0]), .o_dai(dai[0]), .o_lat(lat[0]), .o_busy(busy[0]),
    .o_frame_done(done[0]), .o_overrun(ovr[0]));

  led_chain_driver #(.c_ledboards(1), .c_chains(2), .c_bps(4), .c_clk_div(4),
                     .c_lat_len(2), .c_mode(0), .c_frame_period(300)) u_b (
    .i_clk(clk), .i_rst_n(rst_bc), .i_start(start_bc), .o_addr(addr[1]), .i_data(fb[1]),
    .o_clk(sclk[1]), .o_dai(dai[1]), .o_lat(lat[1]), .o_busy(busy[1]),
    .o_frame_done(done[1]), .o_overrun(ovr[1]));

  led_chain_driver #(.c_ledboards(1), .c_chains(2), .c_bps(4), .c_clk_div(2),
                     .c_lat_len(2), .c_mode(0), .c_frame_period(600)) u_c (
    .i_clk(clk), .i_rst_n(rst_bc), .i_start(start_bc), .o_addr(addr[2]), .i_data(fb[2]),
    .o_clk(sclk[2]), .o_dai(dai[2]), .o_lat(lat[2]), .o_busy(busy[2]),
    .o_frame_done(done[2]), .o_overrun(ovr[2]));

  // Framebuffer with one-cycle read latency: chain0 = a[3:0], chain1 = ~a[3:0]
  always @(posedge clk)
    for (int d = 0; d < 3; d++) fb[d] <= {~addr[d][3:0], addr[d][3:0]};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] outs(input int d);
    return 32'({addr[d], sclk[d], dai[d], lat[d], busy[d], done[d], ovr[d]});
  endfunction

  // Bus-wide monitors: scoreboard pops, serial-timing invariants, event counts
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (sclk[d] && !pclk[d]) begin
        rises[d]++;
        if (d == 0) begin
          check_eq("sb_has_data", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) check_eq("bit", 32'(dai[d]), 32'(sb.pop_front()));
        end
      end
      if (dai[d] != pdai[d]) check_eq("dai_clk_low", 32'(sclk[d]), 0);
      if (addr[d] != paddr[d]) begin
        if (pbusy[d] && busy[d]) check_eq("addr_hold", 32'(hold[d] >= 2), 1);
        hold[d] = 1;
      end else begin
        hold[d]++;
      end
      if (lat[d]) begin
        lat_cyc[d]++;
        check_eq("lat_quiet", 32'({sclk[d], dai[d]}), 0);
      end
      if (done[d]) done_cnt[d]++;
      if (ovr[d]) ovr_cnt[d]++;
      if (busy[d] && !pbusy[d]) busy_up[d]++;
      pclk[d]  = sclk[d];
      pbusy[d] = busy[d];
      pdai[d]  = dai[d];
      paddr[d] = addr[d];
    end
  end

  // One frame on instance A; optionally a stray start or a reset at edge count k
  task automatic run_frame(input int ovr_at, input int abort_at);
    int k, r0, l0, d0, o0, exp_ovr;
    logic [3:0] w;
    r0 = rises[0]; l0 = lat_cyc[0]; d0 = done_cnt[0]; o0 = ovr_cnt[0];
    exp_ovr = (ovr_at >= 0) ? 1 : 0;
    for (int a = 31; a >= 0; a--) begin
      w = 4'(a);
      for (int b = 3; b >= 0; b--) sb.push_back({~w[b], w[b]});
    end
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    check_eq("busy_addr_on", 32'({busy[0], addr[0]}), 32'({1'b1, 5'd31}));
    k = 0;
    while (!done[0] && k < 1000) begin
      start_a = (k == ovr_at);
      if (k == abort_at) rst_a = 1'b0;
      @(posedge clk);
      @(negedge clk);
      k++;
      if (k == 1) check_eq("dai_pre", 32'(dai[0]), 0);
      if (k == 2) check_eq("dai_first", 32'(dai[0]), 32'h1);
      if (k == 3) check_eq("clk_low", 32'(sclk[0]), 0);
      if (k == 4) check_eq("clk_rise", 32'(sclk[0]), 1);
      if (k == ovr_at + 1) check_eq("overrun", 32'(ovr[0]), 1);
      if (k == abort_at + 1) begin
        check_eq("abort_outs", outs(0), 0);
        break;
      end
    end
    start_a = 1'b0;
    if (abort_at >= 0) begin
      rst_a = 1'b1;
      repeat (10) @(negedge clk);
      check_eq("abort_no_lat", 32'(lat_cyc[0] - l0), 0);
      check_eq("abort_no_done", 32'(done_cnt[0] - d0), 0);
      sb.delete();
    end else begin
      check_eq("frame_len", 32'(k), 516);
      check_eq("n_rises", 32'(rises[0] - r0), 128);
      check_eq("sb_drained", 32'(sb.size()), 0);
      check_eq("lat_cycles", 32'(lat_cyc[0] - l0), 2);
      check_eq("n_overrun", 32'(ovr_cnt[0] - o0), 32'(exp_ovr));
    end
  endtask

  initial begin : main_a
    int b0;
    rst_a = 1'b0;
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_a", outs(0), 0);
    rst_a = 1'b1;
    repeat (5) @(negedge clk);
    run_frame(-1, -1);
    run_frame(-1, -1);
    repeat (10) @(negedge clk);
    run_frame(100, -1);
    b0 = busy_up[0];
    repeat (600) @(negedge clk);
    check_eq("no_extra_frame", 32'(busy_up[0] - b0), 0);
    run_frame(-1, 200);
    run_frame(-1, -1);
    wait (bc_done);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Periodic instances: B ticks every 300 (frames longer, overruns), C every 600
  initial begin : main_bc
    logic pb1, pb2;
    rst_bc = 1'b0;
    start_bc = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_b", outs(1), 0);
    check_eq("reset_c", outs(2), 0);
    rst_bc = 1'b1;
    pb1 = 1'b0;
    pb2 = 1'b0;
    for (int n = 0; n < 3100; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (busy[1] && !pb1) check_eq("b_start", 32'(n % 600), 299);
      if (ovr[1]) check_eq("b_ovr", 32'(n % 600), 599);
      if (busy[2] && !pb2) check_eq("c_start", 32'(n % 600), 599);
      pb1 = busy[1];
      pb2 = busy[2];
    end
    repeat (2) @(negedge clk);
    check_eq("b_frames", 32'(busy_up[1]), 5);
    check_eq("b_overruns", 32'(ovr_cnt[1]), 5);
    check_eq("b_done", 32'(done_cnt[1]), 4);
    check_eq("b_lat", 32'(lat_cyc[1]), 8);
    check_eq("c_frames", 32'(busy_up[2]), 5);
    check_eq("c_overruns", 32'(ovr_cnt[2]), 0);
    check_eq("c_done", 32'(done_cnt[2]), 4);
    check_eq("c_lat", 32'(lat_cyc[2]), 8);
    bc_done = 1'b1;
  end

endmodule
